isqrt_pipe: RTL and testbench

Fully pipelined 32-bit unsigned integer square root: y = floor(sqrt(x)). It is the shared isqrt engine fed by the formula FSMs, consuming their isqrt_x/isqrt_x_vld and returning isqrt_y/isqrt_y_vld. It accepts one argument per clock with no backpressure and has fixed latency, so an upstream FSM can track results by counting valids. Operands are carried through the pipe; no state is shared between operations.

---
 rtl/isqrt_pipe.sv | 107 ++++++++++
 tb/tb_isqrt_pipe.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/isqrt_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : isqrt_pipe                                                      |
// | Purpose  : Fully pipelined 32-bit unsigned integer square root,            |
// |            y = floor(sqrt(x)), one argument per clock, fixed latency.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module isqrt_pipe #(
  parameter int n_pipe_stages = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        x_vld,
  input  logic [31:0] x,
  output logic        y_vld,
  output logic [15:0] y
);

  localparam int c_ITERS = 16 / n_pipe_stages;

  // Registered stage outputs; rem/rad of the last stage are never needed.
  logic        r_vld  [n_pipe_stages];
  logic [15:0] r_root [n_pipe_stages];
  logic [17:0] r_rem  [n_pipe_stages];
  logic [31:0] r_rad  [n_pipe_stages];

  // Stage inputs and combinational stage results.
  logic [15:0] w_root_in [n_pipe_stages];
  logic [17:0] w_rem_in  [n_pipe_stages];
  logic [31:0] w_rad_in  [n_pipe_stages];
  logic [15:0] w_root    [n_pipe_stages];
  logic [17:0] w_rem     [n_pipe_stages];
  logic [31:0] w_rad     [n_pipe_stages];

  always_comb begin : comb_stages
    logic [15:0] w_root_t;
    logic [17:0] w_rem_t;
    logic [31:0] w_rad_t;
    logic [17:0] w_trial_t;
    w_root_in = '{default: '0};
    w_rem_in  = '{default: '0};
    w_rad_in  = '{default: '0};
    w_root    = '{default: '0};
    w_rem     = '{default: '0};
    w_rad     = '{default: '0};
    w_root_t  = '0;
    w_rem_t   = '0;
    w_rad_t   = '0;
    w_trial_t = '0;

    w_rad_in[0] = x;
    for (int s = 1; s < n_pipe_stages; s++) begin
      w_root_in[s] = r_root[s-1];
      w_rem_in[s]  = r_rem[s-1];
      w_rad_in[s]  = r_rad[s-1];
    end

    // The radicand is consumed two bits at a time from its MSB end.
    for (int s = 0; s < n_pipe_stages; s++) begin
      w_root_t = w_root_in[s];
      w_rem_t  = w_rem_in[s];
      w_rad_t  = w_rad_in[s];
      for (int j = 0; j < c_ITERS; j++) begin
        w_rem_t   = {w_rem_t[15:0], w_rad_t[31:30]};
        w_rad_t   = {w_rad_t[29:0], 2'b00};
        w_trial_t = {w_root_t, 2'b01};
        if (w_rem_t >= w_trial_t) begin
          w_rem_t  = w_rem_t - w_trial_t;
          w_root_t = {w_root_t[14:0], 1'b1};
        end else begin
          w_root_t = {w_root_t[14:0], 1'b0};
        end
      end
      w_root[s] = w_root_t;
      w_rem[s]  = w_rem_t;
      w_rad[s]  = w_rad_t;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < n_pipe_stages; s++) begin
        r_vld[s]  <= 1'b0;
        r_root[s] <= '0;
        r_rem[s]  <= '0;
        r_rad[s]  <= '0;
      end
    end else begin
      r_vld[0] <= x_vld;
      for (int s = 1; s < n_pipe_stages; s++) begin
        r_vld[s] <= r_vld[s-1];
      end
      for (int s = 0; s < n_pipe_stages; s++) begin
        r_root[s] <= w_root[s];
        if (s < n_pipe_stages - 1) begin
          r_rem[s] <= w_rem[s];
          r_rad[s] <= w_rad[s];
        end
      end
    end
  end

  assign y_vld = r_vld[n_pipe_stages-1];
  assign y     = r_root[n_pipe_stages-1];

endmodule
`default_nettype wire

// File: tb/tb_isqrt_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_isqrt_pipe                                                   |
// | Purpose  : Bench for isqrt_pipe at 1/2/4/8/16 stages against a reference.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_isqrt_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        x_vld;
  logic [31:0] x;
  logic [4:0]  yv;
  logic [15:0] ya [5];

  int checks = 0;
  int errors = 0;

  // Input history indexed by edge number; edge 1 is the first rising edge.
  int          e = 0;
  int          last_rst_e = 0;
  logic        hist_vld [0:16383];
  logic [31:0] hist_x   [0:16383];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_dut
      isqrt_pipe #(.n_pipe_stages(1 << gi)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .x_vld (x_vld),
        .x     (x),
        .y_vld (yv[gi]),
        .y     (ya[gi])
      );
    end
  endgenerate

  // Largest r with r*r <= v, found by binary search on 64-bit products.
  function automatic logic [15:0] ref_isqrt(input logic [31:0] v);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = 65535;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= longint'(v)) lo = mid;
      else hi = mid - 1;
    end
    return lo[15:0];
  endfunction

  always @(posedge clk) begin
    hist_vld[e+1] <= rst_n ? x_vld : 1'b0;
    hist_x[e+1]   <= x;
    e             <= e + 1;
  end

  always @(negedge rst_n) last_rst_e = e;

  always @(negedge clk) begin
    for (int d = 0; d < 5; d++) begin
      int          n;
      int          idx;
      logic        ev;
      logic [15:0] ey;
      n   = 1 << d;
      idx = e - n + 1;
      ev  = 1'b0;
      ey  = 16'd0;
      if (idx >= 1 && idx > last_rst_e) begin
        ev = hist_vld[idx];
        ey = ref_isqrt(hist_x[idx]);
      end
      checks++;
      assert (yv[d] === ev) else begin
        errors++;
        $error("FAIL vld_n%0d edge %0d observed %0b expected %0b", n, e, yv[d], ev);
      end
      if (ev) begin
        checks++;
        assert (ya[d] === ey) else begin
          errors++;
          $error("FAIL y_n%0d edge %0d x=%0h observed %0d expected %0d", n, e, hist_x[idx], ya[d], ey);
        end
      end
      if (!rst_n) begin
        checks++;
        assert (ya[d] === 16'd0) else begin
          errors++;
          $error("FAIL y_rst_n%0d observed %0d expected 0", n, ya[d]);
        end
      end
    end
  end

  task automatic send(input logic v, input logic [31:0] val);
    x_vld = v;
    x     = val;
    @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) send(1'b0, $urandom);
  endtask

  logic [31:0] edge_x   [9] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'hFFFF_FFFF,
                                32'hFFFE_0001, 32'hFFFE_0000, 32'h4000_0000};
  logic [31:0] stream_x [6] = '{32'd9, 32'd15, 32'd16, 32'd100, 32'd65535, 32'd65536};
  logic [31:0] bub_x    [6] = '{32'd49, 32'd7, 32'd81, 32'd24, 32'd7, 32'd1_000_000};
  logic        bub_v    [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    rst_n = 1'b0;
    x_vld = 1'b0;
    x     = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Edge values and extremes, isolated by idle gaps.
    for (int i = 0; i < 9; i++) begin
      send(1'b1, edge_x[i]);
      idle(3);
    end
    idle(18);

    for (int i = 0; i < 6; i++) send(1'b1, stream_x[i]);
    idle(18);

    for (int i = 0; i < 6; i++) send(bub_v[i], bub_x[i]);
    idle(18);

    // Reset in the middle of a burst; nothing in flight may emerge.
    send(1'b1, 32'd1000);
    send(1'b1, 32'd2025);
    send(1'b1, 32'd50);
    x_vld = 1'b1;
    x     = 32'd77;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 5; d++) begin
      checks++;
      assert (yv[d] === 1'b0) else begin
        errors++;
        $error("FAIL async_rst_vld_%0d observed %0b expected 0", d, yv[d]);
      end
      checks++;
      assert (ya[d] === 16'd0) else begin
        errors++;
        $error("FAIL async_rst_y_%0d observed %0d expected 0", d, ya[d]);
      end
    end
    x = 32'd90;
    @(negedge clk);
    @(negedge clk);
    x_vld = 1'b0;
    rst_n = 1'b1;
    idle(20);
    send(1'b1, 32'd144);
    idle(20);

    // Random sweep with a bias toward perfect squares and their neighbours.
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] k;
      logic [31:0] val;
      k = $urandom_range(0, 65535);
      case ($urandom_range(0, 7))
        0:       val = k * k;
        1:       val = k * k - 32'd1;
        2:       val = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        3:       val = edge_x[$urandom_range(0, 8)];
        default: val = $urandom;
      endcase
      send($urandom_range(0, 3) != 0, val);
    end
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
